sdf9_frame_ctrl: RTL and testbench
==================================

Name: sdf9_frame_ctrl

Overview:
Frame sequencer in front of the 9-point radix-3 SDF FFT unit (WIDTH-bit complex, `di_en`/`on` driven).
- Accepts samples over a valid/ready stream and buffers a full 9-sample frame.
- Replays the frame to the FFT as one contiguous `di_en` burst, then enforces a flush gap.
- Frames the FFT output stream with sop/eop/index/frame-id.
- Supervises latency with a watchdog that can soft-reset the FFT.

Parameters:
- WIDTH, 16, real/imag sample width.
- GAP, 12, idle cycles forced after each burst before the next burst (FFT pipeline flush).
- TIMEOUT, 32, max cycles from burst end to first `fft_do_en` before error.
- FID_W, 4, frame-id counter width.

Ports:
- clk  in  1  master clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run control; low = finish current burst/gap, then stay idle
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accepted when s_valid&s_ready
- s_sop  in  1  marks sample 0 of a frame
- s_re  in  WIDTH  input real
- s_im  in  WIDTH  input imag
- fft_rst  out  1  active-high reset to FFT
- fft_on  out  1  FFT `on`
- fft_di_en  out  1  FFT data enable
- fft_di_re  out  WIDTH  FFT data real
- fft_di_im  out  WIDTH  FFT data imag
- fft_do_en  in  1  FFT output enable
- fft_do_re  in  WIDTH  FFT output real
- fft_do_im  in  WIDTH  FFT output imag
- m_valid  out  1  framed output valid (no backpressure)
- m_sop  out  1  output index 0
- m_eop  out  1  output index 8
- m_idx  out  4  output index 0..8
- m_fid  out  FID_W  frame id, wraps
- m_re  out  WIDTH  output real
- m_im  out  WIDTH  output imag
- err_sop  out  1  one-cycle pulse, framing error
- err_timeout  out  1  one-cycle pulse, watchdog fired
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is `clk`, reset port is `rst_n`.
- Reset values:
  - All outputs 0, except `fft_rst`=1; `fft_rst` clears on the first clk edge after `rst_n` deasserts.
  - State IDLE; `m_fid`=0.
- FSM states: IDLE, LOAD, BURST, GAP.
  - IDLE -> LOAD when `enable`=1.
  - LOAD: `s_ready`=1. Samples are written to the 9x2xWIDTH buffer at `wr_idx`.
    - `wr_idx`=0 and s_sop=0: sample dropped, `err_sop` pulses.
    - `wr_idx`!=0 and s_sop=1: partial frame discarded, sample stored as index 0, `wr_idx`=1, `err_sop` pulses.
    - 9th accepted sample -> BURST next cycle.
    - Gaps in s_valid are allowed.
  - BURST: 9 consecutive cycles with `fft_di_en`=`fft_on`=1, data buffer[0..8] in order, `s_ready`=0. Then -> GAP.
  - GAP: GAP cycles with `fft_di_en`=`fft_on`=0 and `fft_di_re`/`fft_di_im`=0. Then -> LOAD if `enable`, else IDLE.
- Latency: first `fft_di_en` is 1 cycle after the 9th sample handshake.
- `enable` falling mid-LOAD: the buffered partial frame is kept; LOAD resumes when `enable` returns.
- Output framing:
  - `m_valid`=`fft_do_en` registered, along with data (1-cycle latency).
  - `m_idx` counts 0..8 over a contiguous `fft_do_en` run; `m_sop`/`m_eop` at 0/8.
  - `m_fid` increments after each eop.
  - A do_en run shorter than 9: counter resets to 0 on do_en low, no eop, `m_fid` unchanged.
  - A run longer than 9: `m_idx` wraps to 0 with a new sop.
- Watchdog:
  - Armed at burst end; cleared by the first `fft_do_en`.
  - If TIMEOUT cycles elapse unarmed-cleared: `err_timeout` pulses, `fft_rst`=1 for exactly 2 cycles, output counter resets.
- Simultaneous timeout and new BURST start: BURST is delayed until `fft_rst` returns to 0.
- `rst_n` assertion mid-operation: everything returns to reset values immediately; buffer contents are don't-care.

Optional Feature:
- Macro: SDF9_PINGPONG_EN.
- Defined: two frame buffers. LOAD of buffer B runs concurrently with BURST/GAP of buffer A, so `s_ready` stays 1 while a free buffer exists.
  - BURST starts when GAP is complete and a full buffer is present.
  - Sustained throughput is 9 samples per 9+GAP cycles.
- Undefined: single buffer, `s_ready`=0 outside LOAD.

Test Plan:
- Single frame: s_sop at sample 0, s_re=1..9, s_im=0, no gaps -> `fft_di_en` high 9 cycles starting 1 cycle after last handshake, `fft_di_re`=1..9; then 12 GAP cycles with `fft_di_en`=0.
- Output framing: bench FFT stub echoes input with latency 11 -> `m_valid` 9 cycles, `m_sop` on idx 0, `m_eop` on idx 8, `m_fid`=0, then `m_fid`=1 for the next frame.
- SOP errors:
  - s_sop asserted at sample 5 -> `err_sop` 1 pulse, frame restarts; burst carries the 9 samples from the second sop onward.
  - Sample without sop at idx 0 -> dropped with `err_sop`.
- Watchdog: stub never asserts `fft_do_en` -> `err_timeout` pulses 32 cycles after burst end, `fft_rst` high 2 cycles, next frame is processed normally.
- Backpressure/enable: s_valid toggling 50%, `enable` dropped during BURST -> burst completes intact, FSM reaches IDLE after GAP with `busy`=0; re-enable resumes LOAD.
- Reset mid-BURST: `rst_n` low at burst cycle 4 -> `fft_di_en`=0 and `fft_rst`=1 immediately; after release the first complete frame bursts correctly with `m_fid` restarting at 0.

Source files
------------

// File: rtl/sdf9_frame_ctrl.sv
// rtl/sdf9_frame_ctrl.sv - 9-point SDF FFT frame sequencer (optional ping-pong buffering: SDF9_PINGPONG_EN)
module sdf9_frame_ctrl #(
  parameter int WIDTH   = 16,
  parameter int GAP     = 12,
  parameter int TIMEOUT = 32,
  parameter int FID_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_sop,
  input  logic [WIDTH-1:0] s_re,
  input  logic [WIDTH-1:0] s_im,
  output logic             fft_rst,
  output logic             fft_on,
  output logic             fft_di_en,
  output logic [WIDTH-1:0] fft_di_re,
  output logic [WIDTH-1:0] fft_di_im,
  input  logic             fft_do_en,
  input  logic [WIDTH-1:0] fft_do_re,
  input  logic [WIDTH-1:0] fft_do_im,
  output logic             m_valid,
  output logic             m_sop,
  output logic             m_eop,
  output logic [3:0]       m_idx,
  output logic [FID_W-1:0] m_fid,
  output logic [WIDTH-1:0] m_re,
  output logic [WIDTH-1:0] m_im,
  output logic             err_sop,
  output logic             err_timeout,
  output logic             busy
);

`ifdef SDF9_PINGPONG_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif
  localparam int GW = $clog2(GAP + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BURST, S_GAP} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] mem_re [NBUF][9];
  logic [WIDTH-1:0] mem_im [NBUF][9];
  logic [3:0]       wr_idx, rd_idx, store_idx, out_cnt;
  logic             wr_sel, rd_sel;
  logic [NBUF-1:0]  full;
  logic [GW-1:0]    gap_cnt;
  logic [WW-1:0]    wd_cnt;
  logic             wd_armed, wd_fire, rst_q, rst_hold;
  logic             accept, store, last_wr, sop_err, frame_rdy, blocked;
  logic             burst_go, burst_last;
  logic [FID_W-1:0] fid;

`ifdef SDF9_PINGPONG_EN
  assign s_ready = (state != S_IDLE) && !full[wr_sel];
`else
  assign s_ready = (state == S_LOAD) && !full[wr_sel];
`endif

  assign accept     = s_valid && s_ready;
  // a sop restarts the frame at index 0; a non-sop sample at index 0 is dropped
  assign store      = accept && (s_sop || (wr_idx != 4'd0));
  assign store_idx  = s_sop ? 4'd0 : wr_idx;
  assign last_wr    = accept && !s_sop && (wr_idx == 4'd8);
  assign sop_err    = accept && (s_sop != (wr_idx == 4'd0));
  assign frame_rdy  = full[rd_sel] || (last_wr && (wr_sel == rd_sel));
  assign wd_fire    = wd_armed && !fft_do_en && (wd_cnt == WW'(TIMEOUT - 1));
  // never start a burst into an FFT that is (about to be) held in reset
  assign blocked    = rst_q || wd_fire;
  assign burst_go   = (state == S_BURST) && ((rd_idx != 4'd0) || !blocked);
  assign burst_last = burst_go && (rd_idx == 4'd8);

  assign fft_di_en = burst_go;
  assign fft_on    = burst_go;
  assign fft_di_re = burst_go ? mem_re[rd_sel][rd_idx] : '0;
  assign fft_di_im = burst_go ? mem_im[rd_sel][rd_idx] : '0;
  assign fft_rst   = rst_q;
  assign busy      = (state != S_IDLE);

  // state register and flush-gap counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nx;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (enable) state_nx = S_LOAD;
      S_LOAD: begin
        if (frame_rdy && !blocked) state_nx = S_BURST;
        else if (!enable)          state_nx = S_IDLE;
      end
      S_BURST: if (burst_last) state_nx = S_GAP;
      S_GAP: begin
        if (gap_cnt == GW'(GAP - 1)) begin
          if (!enable)                    state_nx = S_IDLE;
          else if (frame_rdy && !blocked) state_nx = S_BURST;
          else                            state_nx = S_LOAD;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // frame buffer bookkeeping: write pointer, read pointer, full flags, sop errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx  <= '0;
      rd_idx  <= '0;
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      full    <= '0;
      err_sop <= 1'b0;
    end else begin
      err_sop <= sop_err;
      if (store) begin
        if (last_wr) begin
          wr_idx <= '0;
          if (NBUF == 2) wr_sel <= ~wr_sel;
        end else begin
          wr_idx <= store_idx + 4'd1;
        end
      end
      if (burst_go) rd_idx <= (rd_idx == 4'd8) ? 4'd0 : rd_idx + 4'd1;
      if (burst_last) begin
        full[rd_sel] <= 1'b0;
        if (NBUF == 2) rd_sel <= ~rd_sel;
      end
      if (last_wr) full[wr_sel] <= 1'b1;
    end
  end

  // sample storage, contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (store) begin
      mem_re[wr_sel][store_idx] <= s_re;
      mem_im[wr_sel][store_idx] <= s_im;
    end
  end

  // watchdog and two-cycle FFT soft reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_q       <= 1'b1;
      rst_hold    <= 1'b0;
      err_timeout <= 1'b0;
      wd_armed    <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      err_timeout <= wd_fire;
      if (wd_fire) begin
        rst_q    <= 1'b1;
        rst_hold <= 1'b1;
      end else if (rst_hold) begin
        rst_hold <= 1'b0;
      end else begin
        rst_q <= 1'b0;
      end
      if (burst_last) begin
        wd_armed <= 1'b1;
        wd_cnt   <= WW'(1);
      end else if (wd_armed) begin
        if (fft_do_en || wd_fire) wd_armed <= 1'b0;
        else                      wd_cnt   <= wd_cnt + 1'b1;
      end
    end
  end

  // output framing: register FFT output, count index, advance frame id after eop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_sop   <= 1'b0;
      m_eop   <= 1'b0;
      m_idx   <= '0;
      m_fid   <= '0;
      m_re    <= '0;
      m_im    <= '0;
      out_cnt <= '0;
      fid     <= '0;
    end else begin
      m_valid <= fft_do_en;
      if (fft_do_en) begin
        m_re  <= fft_do_re;
        m_im  <= fft_do_im;
        m_idx <= out_cnt;
        m_sop <= (out_cnt == 4'd0);
        m_eop <= (out_cnt == 4'd8);
        m_fid <= fid;
        if (out_cnt == 4'd8) begin
          out_cnt <= '0;
          fid     <= fid + 1'b1;
        end else begin
          out_cnt <= out_cnt + 4'd1;
        end
      end else begin
        m_sop   <= 1'b0;
        m_eop   <= 1'b0;
        out_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sdf9_frame_ctrl.sv
// tb/tb_sdf9_frame_ctrl.sv - scoreboard bench for sdf9_frame_ctrl with echo FFT stub
module tb_sdf9_frame_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic s_valid = 1'b0;
  logic s_sop = 1'b0;
  logic [W-1:0] s_re = '0;
  logic [W-1:0] s_im = '0;
  logic s_ready, fft_rst, fft_on, fft_di_en;
  logic [W-1:0] fft_di_re, fft_di_im, fft_do_re, fft_do_im, m_re, m_im;
  logic fft_do_en, m_valid, m_sop, m_eop, err_sop, err_timeout, busy;
  logic [3:0] m_idx, m_fid;

  sdf9_frame_ctrl #(.WIDTH(W), .GAP(12), .TIMEOUT(32), .FID_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_sop(s_sop), .s_re(s_re), .s_im(s_im),
    .fft_rst(fft_rst), .fft_on(fft_on), .fft_di_en(fft_di_en),
    .fft_di_re(fft_di_re), .fft_di_im(fft_di_im),
    .fft_do_en(fft_do_en), .fft_do_re(fft_do_re), .fft_do_im(fft_do_im),
    .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_idx(m_idx), .m_fid(m_fid),
    .m_re(m_re), .m_im(m_im), .err_sop(err_sop), .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // FFT stub: echoes di with 11-cycle latency, flushed by fft_rst
  bit stub_mute = 1'b0;
  logic [10:0] d_en = '0;
  logic [W-1:0] d_re [11];
  logic [W-1:0] d_im [11];
  always @(posedge clk) begin
    if (fft_rst) d_en <= '0;
    else         d_en <= {d_en[9:0], fft_di_en & ~stub_mute};
    d_re[0] <= fft_di_re;
    d_im[0] <= fft_di_im;
    for (int i = 1; i < 11; i++) begin
      d_re[i] <= d_re[i-1];
      d_im[i] <= d_im[i-1];
    end
  end
  assign fft_do_en = d_en[10];
  assign fft_do_re = d_re[10];
  assign fft_do_im = d_im[10];

  // scoreboard queues and monitor state
  logic [31:0] exp_in[$];
  logic [31:0] exp_out[$];
  logic [31:0] mon_e;
  bit prev_di = 1'b0;
  int di_run = 0, last_di_cyc = 0, n_err_sop = 0, n_to = 0, n_frst = 0, mi = 0;
  logic [3:0] mf = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_di = 1'b0;
      di_run = 0;
      mi = 0;
      mf = '0;
    end else begin
      if (fft_di_en) begin
        last_di_cyc = cyc;
        di_run++;
        if (exp_in.size() == 0) chk("di_unexpected", 64'(fft_di_en), 64'd0);
        else begin
          mon_e = exp_in.pop_front();
          chk("di_data", 64'({fft_di_re, fft_di_im}), 64'(mon_e));
          if (!stub_mute) exp_out.push_back(mon_e);
        end
      end else if (prev_di) begin
        chk("burst_len", 64'(di_run), 64'd9);
        di_run = 0;
      end
      prev_di = fft_di_en;
      if (m_valid) begin
        if (exp_out.size() == 0) chk("m_unexpected", 64'(m_valid), 64'd0);
        else begin
          mon_e = exp_out.pop_front();
          chk("m_data", 64'({m_re, m_im}), 64'(mon_e));
        end
        chk("m_frame", 64'({m_idx, m_sop, m_eop, m_fid}), 64'({mi[3:0], mi == 0, mi == 8, mf}));
        if (mi == 8) begin
          mi = 0;
          mf = mf + 4'd1;
        end else mi++;
      end else mi = 0;
      if (err_sop) n_err_sop++;
      if (err_timeout) n_to++;
      if (fft_rst) n_frst++;
    end
  end

  int hs_cyc = 0;
  task automatic push_sample(input logic [W-1:0] re, input logic [W-1:0] im, input logic sop);
    int k;
    s_valid = 1'b1; s_re = re; s_im = im; s_sop = sop;
    k = 0;
    @(negedge clk);
    while (!s_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!s_ready) chk("ready_wait", 64'(s_ready), 64'd1);
    hs_cyc = cyc;
    @(posedge clk); #1;
    s_valid = 1'b0; s_sop = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] bre, input logic [W-1:0] bim, input bit gappy);
    logic [W-1:0] r;
    for (int i = 0; i < 9; i++) begin
      r = bre + W'(i);
      exp_in.push_back({r, bim});
    end
    for (int i = 0; i < 9; i++) begin
      r = bre + W'(i);
      push_sample(r, bim, i == 0);
      if (gappy) begin @(posedge clk); #1; end
    end
  endtask

  int k, e0, t0, r0;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_fft_rst", 64'(fft_rst), 64'd1);
    chk("rst_outs", 64'({fft_di_en, fft_on, s_ready, m_valid, m_sop, m_eop, err_sop, err_timeout, busy}), 64'd0);
    chk("rst_fid_idx", 64'({m_fid, m_idx}), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); chk("fft_rst_hold", 64'(fft_rst), 64'd1);
    @(negedge clk); chk("fft_rst_clear", 64'(fft_rst), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1; enable = 1'b1;

    // single frame, latency and flush gap
    send_frame(16'd1, 16'd0, 1'b0);
    @(negedge clk);
    k = 0;
    while (!fft_di_en && k < 50) begin @(negedge clk); k++; end
    chk("burst_latency", 64'(cyc), 64'(hs_cyc + 1));
    k = 0;
    while (fft_di_en && k < 50) begin @(negedge clk); k++; end
    for (int i = 0; i < 12; i++) begin
      chk("gap_quiet", 64'({fft_di_en, fft_on, fft_di_re, fft_di_im, s_ready}), 64'd0);
      @(negedge clk);
    end
    chk("gap_end_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;

    // second frame, frame id advances
    send_frame(16'h0100, 16'h00aa, 1'b0);
    repeat (40) @(negedge clk);
    chk("fid_frame2", 64'(m_fid), 64'd1);

    // sop at sample 5 restarts the frame
    e0 = n_err_sop;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) push_sample(16'h0200 + W'(i), 16'h0, i == 0);
    send_frame(16'h0300, 16'h0033, 1'b0);
    repeat (40) @(negedge clk);
    chk("sop_restart_err", 64'(n_err_sop - e0), 64'd1);

    // sample without sop at index 0 is dropped
    e0 = n_err_sop;
    @(posedge clk); #1;
    push_sample(16'h00dd, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk("sop_missing_err", 64'(n_err_sop - e0), 64'd1);
    @(posedge clk); #1;
    send_frame(16'h0400, 16'h0044, 1'b0);
    repeat (40) @(negedge clk);

    // watchdog: FFT never answers
    stub_mute = 1'b1;
    r0 = n_frst;
    t0 = n_to;
    @(posedge clk); #1;
    send_frame(16'h0500, 16'h0055, 1'b0);
    @(negedge clk);
    k = 0;
    while (!err_timeout && k < 100) begin @(negedge clk); k++; end
    chk("to_seen", 64'(err_timeout), 64'd1);
    chk("to_delay", 64'(cyc - last_di_cyc), 64'd32);
    chk("to_rst_1", 64'(fft_rst), 64'd1);
    @(negedge clk);
    chk("to_pulse", 64'(err_timeout), 64'd0);
    chk("to_rst_2", 64'(fft_rst), 64'd1);
    @(negedge clk);
    chk("to_rst_off", 64'(fft_rst), 64'd0);
    @(negedge clk);
    chk("to_rst_cycles", 64'(n_frst - r0), 64'd2);
    chk("to_count", 64'(n_to - t0), 64'd1);
    stub_mute = 1'b0;
    @(posedge clk); #1;
    send_frame(16'h0600, 16'h0066, 1'b0);
    repeat (40) @(negedge clk);

    // 50% valid, enable dropped during the burst
    @(posedge clk); #1;
    send_frame(16'h0700, 16'h0077, 1'b1);
    enable = 1'b0;
    @(negedge clk);
    k = 0;
    while (busy && k < 60) begin @(negedge clk); k++; end
    chk("idle_reached", 64'(busy), 64'd0);
    chk("idle_delay", 64'(cyc - last_di_cyc), 64'd13);
    chk("idle_ready", 64'(s_ready), 64'd0);
    repeat (5) @(negedge clk);
    chk("idle_stays", 64'(busy), 64'd0);
    @(posedge clk); #1;
    enable = 1'b1;
    send_frame(16'h0800, 16'h0088, 1'b0);
    repeat (40) @(negedge clk);

    // reset in burst cycle 4
    @(posedge clk); #1;
    send_frame(16'h0900, 16'h0099, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_in.delete();
    exp_out.delete();
    #1;
    chk("rst_mid_di", 64'(fft_di_en), 64'd0);
    chk("rst_mid_frst", 64'(fft_rst), 64'd1);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(16'h0a00, 16'h00a5, 1'b0);
    repeat (40) @(negedge clk);
    chk("fid_restart", 64'(m_fid), 64'd0);

    chk("sb_in_empty", 64'(exp_in.size()), 64'd0);
    chk("sb_out_empty", 64'(exp_out.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
